// File: rtl/rs485_tx_sched.sv
// Round-robin RS-485 transmit scheduler: one shared serializer for X/Y/Z.
// Optional even-parity bit between data and stop when RS485_PARITY_EN is defined.
module rs485_tx_sched #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned GUARD_PRE  = 8,
  parameter int unsigned GUARD_POST = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [7:0] data_x,
  input  logic [7:0] data_y,
  input  logic [7:0] data_z,
  output logic [2:0] ack,
  output logic [1:0] grant,
  output logic       busy,
  output logic       TxD_X,
  output logic       TxD_Y,
  output logic       TxD_Z,
  output logic       DE_X,
  output logic       DE_Y,
  output logic       DE_Z
);

  localparam int unsigned M1 =
    (CLK_DIV > GUARD_PRE) ? CLK_DIV : GUARD_PRE;
  localparam int unsigned MAXC =
    (M1 > GUARD_POST) ? M1 : GUARD_POST;
  localparam int unsigned CW = $clog2(MAXC);

  localparam logic [CW-1:0] PRE_END  = CW'(GUARD_PRE - 1);
  localparam logic [CW-1:0] DIV_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] POST_END = CW'(GUARD_POST - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    START,
    DATA,
`ifdef RS485_PARITY_EN
    PARITY,
`endif
    STOP,
    POST
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    last_q, last_d;
  logic [7:0]    data_q, data_d;
  logic [2:0]    ack_q, ack_d;
  logic [2:0]    txd_q, txd_d;
  logic [2:0]    de_q, de_d;
  logic          busy_q;
  logic [1:0]    sel;
  logic [7:0]    sel_data;
  logic          tx_bit;

  // Search begins one past the last granted channel.
  always_comb begin
    sel = 2'd0;
    unique case (last_q)
      2'd0: sel = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1: sel = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: sel = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    sel_data = data_z;
    unique case (1'b1)
      (sel == 2'd0): sel_data = data_x;
      (sel == 2'd1): sel_data = data_y;
      default:       sel_data = data_z;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    grant_d = grant_q;
    last_d  = last_q;
    data_d  = data_q;
    ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        bit_d   = '0;
        grant_d = 2'd3;
        if (|req) begin
          state_d    = PRE;
          grant_d    = sel;
          last_d     = sel;
          data_d     = sel_data;
          ack_d[sel] = 1'b1;
        end
      end
      PRE: if (cnt_q == PRE_END) begin
        state_d = START;
        cnt_d   = '0;
      end
      START: if (cnt_q == DIV_END) begin
        state_d = DATA;
        cnt_d   = '0;
        bit_d   = '0;
      end
      DATA: if (cnt_q == DIV_END) begin
        cnt_d = '0;
        if (bit_q == 3'd7) begin
`ifdef RS485_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
          bit_d = '0;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
`ifdef RS485_PARITY_EN
      PARITY: if (cnt_q == DIV_END) begin
        state_d = STOP;
        cnt_d   = '0;
      end
`endif
      STOP: if (cnt_q == DIV_END) begin
        state_d = POST;
        cnt_d   = '0;
      end
      POST: if (cnt_q == POST_END) begin
        state_d = IDLE;
        cnt_d   = '0;
        grant_d = 2'd3;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        grant_d = 2'd3;
      end
    endcase
  end

  // Line outputs follow the next state so they stay registered yet aligned.
  always_comb begin
    tx_bit = 1'b1;
    unique case (state_d)
      START:   tx_bit = 1'b0;
      DATA:    tx_bit = data_d[bit_d];
`ifdef RS485_PARITY_EN
      PARITY:  tx_bit = ^data_d;
`endif
      default: tx_bit = 1'b1;
    endcase
    txd_d = 3'b111;
    de_d  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (state_d != IDLE && grant_d == 2'(i)) begin
        txd_d[i] = tx_bit;
        de_d[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      grant_q <= 2'd3;
      last_q  <= 2'd2;
      data_q  <= '0;
      ack_q   <= '0;
      txd_q   <= 3'b111;
      de_q    <= 3'b000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      txd_q   <= txd_d;
      de_q    <= de_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign ack   = ack_q;
  assign grant = grant_q;
  assign busy  = busy_q;
  assign TxD_X = txd_q[0];
  assign TxD_Y = txd_q[1];
  assign TxD_Z = txd_q[2];
  assign DE_X  = de_q[0];
  assign DE_Y  = de_q[1];
  assign DE_Z  = de_q[2];

endmodule

// File: tb/tb_rs485_tx_sched.sv
// Directed bench for rs485_tx_sched (CLK_DIV=4, GUARD_PRE=2, GUARD_POST=2).
// Expected waveforms come from a per-cycle frame model in this file.
module tb_rs485_tx_sched;

  localparam int DIV   = 4;
  localparam int GPRE  = 2;
  localparam int GPOST = 2;
`ifdef RS485_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = GPRE + NB * DIV + GPOST;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] req = '0;
  logic [7:0] data_x = '0;
  logic [7:0] data_y = '0;
  logic [7:0] data_z = '0;
  logic [2:0] ack;
  logic [1:0] grant;
  logic       busy;
  logic       TxD_X, TxD_Y, TxD_Z;
  logic       DE_X, DE_Y, DE_Z;
  logic [11:0] obs;

  int pass_cnt = 0;
  int total_cnt = 0;

  rs485_tx_sched #(
    .CLK_DIV(DIV),
    .GUARD_PRE(GPRE),
    .GUARD_POST(GPOST)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .data_x(data_x), .data_y(data_y), .data_z(data_z),
    .ack(ack), .grant(grant), .busy(busy),
    .TxD_X(TxD_X), .TxD_Y(TxD_Y), .TxD_Z(TxD_Z),
    .DE_X(DE_X), .DE_Y(DE_Y), .DE_Z(DE_Z)
  );

  always #5 clk = ~clk;

  assign obs = {ack, grant, busy, DE_Z, DE_Y, DE_X,
                TxD_Z, TxD_Y, TxD_X};

  localparam logic [11:0] IDLE_V = {3'b000, 2'd3, 1'b0,
                                    3'b000, 3'b111};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    step();
    rst = 1'b1;
  endtask

  function automatic logic exp_tx(input logic [7:0] d, input int k);
    int j;
    j = k;
    if (j < GPRE) return 1'b1;
    j -= GPRE;
    if (j < DIV) return 1'b0;
    j -= DIV;
    if (j < 8 * DIV) return d[j / DIV];
    j -= 8 * DIV;
`ifdef RS485_PARITY_EN
    if (j < DIV) return ^d;
`endif
    return 1'b1;
  endfunction

  function automatic logic [11:0] exp_vec(input int ch,
                                          input logic [7:0] d,
                                          input int k);
    logic [2:0] a, de, tx;
    if (k >= FL) return IDLE_V;
    a  = (k == 0) ? 3'(1 << ch) : 3'b000;
    de = 3'(1 << ch);
    tx = 3'b111;
    tx[ch] = exp_tx(d, k);
    return {a, 2'(ch), 1'b1, de, tx};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (obs !== IDLE_V)
        $display("FAIL reset i=%0d got %h want %h", i, obs, IDLE_V);
      else pass_cnt++;
    end
    req = '0;
    rst = 1'b1;
  endtask

  task automatic test_single_x();
    logic [11:0] e;
    do_reset();
    data_x = 8'hA5;
    req = 3'b001;
    for (int k = 0; k <= FL; k++) begin
      step();
      if (k == 0) req = '0;
      e = exp_vec(0, 8'hA5, k);
      total_cnt++;
      if (obs !== e)
        $display("FAIL single_x k=%0d got %h want %h", k, obs, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_round_robin3();
    logic [11:0] e;
    logic [7:0]  d [3];
    d[0] = 8'h11; d[1] = 8'h3C; d[2] = 8'hF0;
    do_reset();
    data_x = d[0]; data_y = d[1]; data_z = d[2];
    req = 3'b111;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k <= FL; k++) begin
        step();
        if (k == 0) req[f] = 1'b0;
        e = exp_vec(f, d[f], k);
        total_cnt++;
        if (obs !== e)
          $display("FAIL rr3 f=%0d k=%0d got %h want %h", f, k, obs, e);
        else pass_cnt++;
      end
    end
    step();
    total_cnt++;
    if (obs !== IDLE_V)
      $display("FAIL rr3_tail got %h want %h", obs, IDLE_V);
    else pass_cnt++;
  endtask

  task automatic test_round_robin2();
    logic [11:0] e;
    int ch;
    do_reset();
    data_x = 8'h81; data_y = 8'h42;
    req = 3'b011;
    for (int f = 0; f < 4; f++) begin
      ch = f % 2;
      for (int k = 0; k <= FL; k++) begin
        step();
        if (k == 0 && f == 3) req = '0;
        e = exp_vec(ch, (ch == 0) ? 8'h81 : 8'h42, k);
        total_cnt++;
        if (obs !== e)
          $display("FAIL rr2 f=%0d k=%0d got %h want %h", f, k, obs, e);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] e;
    do_reset();
    data_x = 8'h5A;
    req = 3'b001;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 0) req = '0;
      e = exp_vec(0, 8'h5A, k);
      total_cnt++;
      if (obs !== e)
        $display("FAIL mid_pre k=%0d got %h want %h", k, obs, e);
      else pass_cnt++;
    end
    rst = 1'b0;
    req = 3'b001;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (obs !== IDLE_V)
        $display("FAIL mid_rst i=%0d got %h want %h", i, obs, IDLE_V);
      else pass_cnt++;
    end
    req = '0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if (obs !== IDLE_V)
        $display("FAIL mid_after i=%0d got %h want %h", i, obs, IDLE_V);
      else pass_cnt++;
    end
  endtask

  task automatic test_dropped_req();
    logic [11:0] e;
    do_reset();
    data_x = 8'hC3; data_y = 8'hFF;
    req = 3'b001;
    for (int k = 0; k <= FL + 3; k++) begin
      step();
      if (k == 0) req = '0;
      if (k == 10) req = 3'b010;
      if (k == 11) req = '0;
      e = exp_vec(0, 8'hC3, k);
      total_cnt++;
      if (obs !== e)
        $display("FAIL drop k=%0d got %h want %h", k, obs, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_chan_z();
    logic [11:0] e;
    int de_len;
    do_reset();
    data_z = 8'h07;
    req = 3'b100;
    de_len = 0;
    for (int k = 0; k <= FL; k++) begin
      step();
      if (k == 0) req = '0;
      if (DE_Z === 1'b1) de_len++;
      e = exp_vec(2, 8'h07, k);
      total_cnt++;
      if (obs !== e)
        $display("FAIL chan_z k=%0d got %h want %h", k, obs, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (de_len != FL)
      $display("FAIL chan_z_de_len got %0d want %0d", de_len, FL);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_x();
    test_round_robin3();
    test_round_robin2();
    test_reset_mid();
    test_dropped_req();
    test_chan_z();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
